frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/gpu_pkg.sv | 28 ++
 rtl/frame_scheduler_if.sv | 29 ++
 rtl/scan_counter.sv | 58 +++++
 rtl/frame_scheduler.sv | 158 +++++++++++++++
 tb/tb_frame_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the frame scheduler.
// - state_e : scheduler FSM states
// - voxel_t : packed voxel record {x, y, z, id}, x in the MSBs (default widths)
package gpu_pkg;

  localparam int unsigned CoordBits   = 8;
  localparam int unsigned PaletteBits = 8;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StLoad,
    StRaster,
    StRasterWait,
    StShade,
    StShadeWait,
    StReadout,
    StDone
  } state_e;

  typedef struct packed {
    logic [CoordBits-1:0]   x;
    logic [CoordBits-1:0]   y;
    logic [CoordBits-1:0]   z;
    logic [PaletteBits-1:0] id;
  } voxel_t;

endpackage

// File: rtl/frame_scheduler_if.sv
// Bus bundle between the frame scheduler and its memories.
// - voxel memory read port: voxel_addr, voxel_rd (out), voxel_rdata (in, 1-cycle latency)
// - pixel stream to framebuffer: pix_out, pix_valid (out), pix_ready (in)
// master = scheduler side, slave = memory / framebuffer side.
interface frame_scheduler_if #(
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned COORD_BITS   = 8,
  parameter int unsigned PALETTE_BITS = 8,
  parameter int unsigned PIXEL_BITS   = 8
) ();

  logic [ADDR_BITS-1:0]                   voxel_addr;
  logic                                   voxel_rd;
  logic [3*COORD_BITS+PALETTE_BITS-1:0]   voxel_rdata;
  logic [PIXEL_BITS-1:0]                  pix_out;
  logic                                   pix_valid;
  logic                                   pix_ready;

  modport master (
    output voxel_addr, voxel_rd, pix_out, pix_valid,
    input  voxel_rdata, pix_ready
  );

  modport slave (
    input  voxel_addr, voxel_rd, pix_out, pix_valid,
    output voxel_rdata, pix_ready
  );

endinterface

// File: rtl/scan_counter.sv
// Row-major raster counter for pixel readout.
// - clear_i : synchronous return to (0,0)
// - en_i    : advance one position; col wraps to 0 and row advances at COLS-1
// - row_o/col_o : current position
// - last_o  : position is (ROWS-1, COLS-1)
module scan_counter #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned ROW_BITS = 8,
  parameter int unsigned COL_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                en_i,
  output logic [ROW_BITS-1:0] row_o,
  output logic [COL_BITS-1:0] col_o,
  output logic                last_o
);

  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                row_last, col_last;

  assign row_last = (row_q == ROW_BITS'(ROWS - 1));
  assign col_last = (col_q == COL_BITS'(COLS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_BITS'(1);
      end else begin
        col_d = col_q + COL_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = row_last & col_last;

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: fetches voxel_count voxels, broadcasts each to the shader array
// with a rasterize command, then issues one shade command and streams the ROWS x COLS
// pixel array out row-major through a valid/ready handshake.
// Ports:
// - clock, resetn       : clock and asynchronous active-low reset
// - start, voxel_count  : frame request (honoured only in IDLE)
// - busy, frame_done    : status; frame_done pulses for the DONE cycle
// - bus (master)        : voxel memory read port and pixel output stream
// - voxel_x/y/z/id      : voxel broadcast, held from LOAD to the next LOAD
// - do_rasterize/do_shade, all_rasterized/all_shaded : shader commands and completion
// - row, col, pixel_in  : readout select and shared shader pixel bus
module frame_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned ROW_BITS     = 8,
  parameter int unsigned COL_BITS     = 8,
  parameter int unsigned COORD_BITS   = 8,
  parameter int unsigned PALETTE_BITS = 8,
  parameter int unsigned PIXEL_BITS   = 8,
  parameter int unsigned ADDR_BITS    = 10
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [ADDR_BITS:0]      voxel_count,
  output logic                    busy,
  output logic                    frame_done,
  frame_scheduler_if.master       bus,
  output logic [COORD_BITS-1:0]   voxel_x,
  output logic [COORD_BITS-1:0]   voxel_y,
  output logic [COORD_BITS-1:0]   voxel_z,
  output logic [PALETTE_BITS-1:0] voxel_id,
  output logic                    do_rasterize,
  output logic                    do_shade,
  input  logic                    all_rasterized,
  input  logic                    all_shaded,
  output logic [ROW_BITS-1:0]     row,
  output logic [COL_BITS-1:0]     col,
  input  logic [PIXEL_BITS-1:0]   pixel_in
);

  localparam int unsigned VoxW = 3 * COORD_BITS + PALETTE_BITS;

  state_e                state_q, state_d;
  // One bit wider than the address so a full 2^ADDR_BITS frame terminates cleanly.
  logic [ADDR_BITS:0]    index_q, index_d;
  logic [ADDR_BITS:0]    count_q, count_d;
  logic [VoxW-1:0]       voxel_q, voxel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_q, rd_d;
  logic                  rast_q, rast_d;
  logic                  shade_q, shade_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  pix_hs;
  logic                  scan_last;

  assign pix_hs = pix_valid_q & bus.pix_ready;

  scan_counter #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_scan (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .clear_i (state_q != StReadout),
    .en_i    (pix_hs),
    .row_o   (row),
    .col_o   (col),
    .last_o  (scan_last)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    voxel_d = voxel_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = voxel_count;
          index_d = '0;
          state_d = (voxel_count != '0) ? StFetch : StShade;
        end
      end
      StFetch:  state_d = StLoad;
      StLoad: begin
        voxel_d = bus.voxel_rdata;
        state_d = StRaster;
      end
      StRaster: state_d = StRasterWait;
      StRasterWait: begin
        if (all_rasterized) begin
          index_d = index_q + (ADDR_BITS + 1)'(1);
          state_d = (index_d == count_q) ? StShade : StFetch;
        end
      end
      StShade:     state_d = StShadeWait;
      StShadeWait: if (all_shaded) state_d = StReadout;
      StReadout:   if (pix_hs && scan_last) state_d = StDone;
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase

    // Strobes are registered from the next state so they are high exactly in their state.
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    rd_d        = (state_d == StFetch);
    rast_d      = (state_d == StRaster);
    shade_d     = (state_d == StShade);
    pix_valid_d = (state_d == StReadout);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      index_q     <= '0;
      count_q     <= '0;
      voxel_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= 1'b0;
      rast_q      <= 1'b0;
      shade_q     <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      count_q     <= count_d;
      voxel_q     <= voxel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_q        <= rd_d;
      rast_q      <= rast_d;
      shade_q     <= shade_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign do_rasterize   = rast_q;
  assign do_shade       = shade_q;
  assign bus.voxel_rd   = rd_q;
  assign bus.voxel_addr = index_q[ADDR_BITS-1:0];
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_out    = pix_valid_q ? pixel_in : '0;

  assign voxel_x  = voxel_q[VoxW-1 -: COORD_BITS];
  assign voxel_y  = voxel_q[VoxW-COORD_BITS-1 -: COORD_BITS];
  assign voxel_z  = voxel_q[VoxW-2*COORD_BITS-1 -: COORD_BITS];
  assign voxel_id = voxel_q[PALETTE_BITS-1:0];

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler (default parameters, 4x4 array).
module tb_frame_scheduler;
  import gpu_pkg::*;

  localparam int unsigned AB = 10;

  logic          clock = 1'b0;
  logic          resetn;
  logic          start;
  logic [AB:0]   voxel_count;
  logic          busy, frame_done;
  logic [7:0]    voxel_x, voxel_y, voxel_z, voxel_id;
  logic          do_rasterize, do_shade;
  logic          all_rasterized, all_shaded;
  logic [7:0]    row, col, pixel_in;

  frame_scheduler_if #(.ADDR_BITS(AB), .COORD_BITS(8), .PALETTE_BITS(8), .PIXEL_BITS(8)) bus ();

  frame_scheduler dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .voxel_count    (voxel_count),
    .busy           (busy),
    .frame_done     (frame_done),
    .bus            (bus),
    .voxel_x        (voxel_x),
    .voxel_y        (voxel_y),
    .voxel_z        (voxel_z),
    .voxel_id       (voxel_id),
    .do_rasterize   (do_rasterize),
    .do_shade       (do_shade),
    .all_rasterized (all_rasterized),
    .all_shaded     (all_shaded),
    .row            (row),
    .col            (col),
    .pixel_in       (pixel_in)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic voxel_t voxel_of(input logic [AB-1:0] a);
    voxel_t v;
    v.x  = a[7:0];
    v.y  = a[7:0] + 8'd1;
    v.z  = a[7:0] + 8'd2;
    v.id = ~a[7:0];
    return v;
  endfunction

  function automatic logic [7:0] exp_pix(input int n);
    return {4'(n / 4), 4'(n % 4)};
  endfunction

  // Voxel memory: one-cycle read latency.
  initial bus.voxel_rdata = '0;
  always @(posedge clock) if (bus.voxel_rd) bus.voxel_rdata <= voxel_of(bus.voxel_addr);

  // Shader array: done pulses 2 cycles after rasterize, 3 cycles after shade.
  int rast_dly = 0;
  int shade_dly = 0;
  always @(posedge clock) begin
    if (do_rasterize) rast_dly <= 2;
    else if (rast_dly > 0) rast_dly <= rast_dly - 1;
    if (do_shade) shade_dly <= 3;
    else if (shade_dly > 0) shade_dly <= shade_dly - 1;
  end
  assign all_rasterized = (rast_dly == 1);
  assign all_shaded     = (shade_dly == 1);
  assign pixel_in       = {row[3:0], col[3:0]};

  // Per-frame monitor counters, cleared by the main sequence.
  int          cyc = 0;
  int          n_reads, n_raster, n_shade, n_pix, n_done, last_hs_cyc;
  logic [AB-1:0] last_addr;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (resetn) begin
      if (bus.voxel_rd) begin
        check("rd_addr", bus.voxel_addr, n_reads);
        last_addr = bus.voxel_addr;
        n_reads++;
      end
      if (do_rasterize) begin
        voxel_t v;
        v = voxel_of(last_addr);
        check("voxel_fields", {voxel_x, voxel_y, voxel_z, voxel_id}, v);
        n_raster++;
      end
      if (do_shade) n_shade++;
      if (do_rasterize || do_shade) check("rast_shade_excl", do_rasterize & do_shade, 0);
      if (bus.pix_valid) check("pix_passthru", bus.pix_out, pixel_in);
      if (bus.pix_valid && bus.pix_ready) begin
        check("pixel_seq", bus.pix_out, exp_pix(n_pix));
        n_pix++;
        last_hs_cyc = cyc;
      end
      if (frame_done) begin
        check("done_latency", cyc - last_hs_cyc, 1);
        n_done++;
      end
    end
  end

  task automatic clear_counts();
    n_reads = 0; n_raster = 0; n_shade = 0; n_pix = 0; n_done = 0;
    last_hs_cyc = 0; last_addr = '0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after the accepted start.
  task automatic start_frame(input int c);
    clear_counts();
    voxel_count = (AB + 1)'(c);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 20000 && n_done == 0; i++) @(posedge clock);
    if (n_done == 0) check("frame_timeout", 0, 1);
    @(posedge clock); #1;
    check("idle_after_done", busy, 0);
  endtask

  task automatic wait_for_rast();
    int i;
    for (i = 0; i < 200 && !do_rasterize; i++) begin @(posedge clock); #1; end
    check("saw_rasterize", do_rasterize, 1);
  endtask

  typedef struct {
    int count;
    int exp_reads;
    int exp_raster;
    int exp_shade;
    int exp_pixels;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{count: 3,    exp_reads: 3,    exp_raster: 3,    exp_shade: 1, exp_pixels: 16};
    vecs[1] = '{count: 0,    exp_reads: 0,    exp_raster: 0,    exp_shade: 1, exp_pixels: 16};
    vecs[2] = '{count: 1,    exp_reads: 1,    exp_raster: 1,    exp_shade: 1, exp_pixels: 16};
    vecs[3] = '{count: 5,    exp_reads: 5,    exp_raster: 5,    exp_shade: 1, exp_pixels: 16};
    vecs[4] = '{count: 1024, exp_reads: 1024, exp_raster: 1024, exp_shade: 1, exp_pixels: 16};

    start = 1'b0;
    voxel_count = '0;
    bus.pix_ready = 1'b1;
    resetn = 1'b0;
    clear_counts();
    repeat (3) @(posedge clock);
    #1;
    check("reset_strobes", {busy, frame_done, bus.voxel_rd, do_rasterize, do_shade, bus.pix_valid}, 0);
    check("reset_rowcol", {row, col}, 0);
    check("reset_voxel", {voxel_x, voxel_y, voxel_z, voxel_id}, 0);
    check("reset_addr", bus.voxel_addr, 0);
    check("reset_pix_out", bus.pix_out, 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int k = 0; k < 5; k++) begin
      start_frame(vecs[k].count);
      wait_done();
      check("reads", n_reads, vecs[k].exp_reads);
      check("rasters", n_raster, vecs[k].exp_raster);
      check("shades", n_shade, vecs[k].exp_shade);
      check("pixels", n_pix, vecs[k].exp_pixels);
      check("dones", n_done, 1);
      if (vecs[k].count > 0) check("last_addr", last_addr, vecs[k].count - 1);
    end

    // Count 3: FETCH immediately follows start.
    start_frame(3);
    check("fetch_after_start", bus.voxel_rd, 1);
    wait_done();

    // Count 0: SHADE immediately follows start.
    start_frame(0);
    check("zero_shade_next", do_shade, 1);
    check("zero_no_rd", bus.voxel_rd, 0);
    wait_done();
    check("zero_reads", n_reads + n_raster, 0);

    // Backpressure at (1,2) for 5 cycles.
    start_frame(1);
    begin
      int i;
      for (i = 0; i < 200 && !(bus.pix_valid && row == 8'd1 && col == 8'd2); i++) begin
        @(posedge clock); #1;
      end
      check("reach_1_2", {row, col}, 16'h0102);
      bus.pix_ready = 1'b0;
      repeat (5) begin
        @(posedge clock); #1;
        check("stall_hold", {bus.pix_valid, row, col}, {1'b1, 16'h0102});
      end
      bus.pix_ready = 1'b1;
    end
    wait_done();
    check("stall_pixels", n_pix, 16);

    // Start while busy is ignored.
    start_frame(2);
    wait_for_rast();
    voxel_count = (AB + 1)'(7);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done();
    check("busy_start_reads", n_reads, 2);
    check("busy_start_rasters", n_raster, 2);

    // Start coinciding with DONE is ignored.
    start_frame(0);
    begin
      int i;
      for (i = 0; i < 200 && !frame_done; i++) begin @(posedge clock); #1; end
      check("saw_done", frame_done, 1);
      voxel_count = (AB + 1)'(3);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("done_start_ignored", {busy, bus.voxel_rd}, 0);
    end

    // Reset in RASTER_WAIT abandons the frame.
    start_frame(3);
    wait_for_rast();
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_strobes", {frame_done, do_rasterize, do_shade, bus.voxel_rd}, 0);
    check("abort_voxel", {voxel_x, voxel_y, voxel_z, voxel_id}, 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    check("abort_no_done", n_done, 0);
    @(posedge clock); #1;
    start_frame(2);
    wait_done();
    check("after_abort_reads", n_reads, 2);
    check("after_abort_rasters", n_raster, 2);
    check("after_abort_pixels", n_pix, 16);
    check("after_abort_dones", n_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
